// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg: register offsets, CTRL/STATUS bit positions and prescaler default shared by the timer
package timer_irq_pkg;

    localparam logic [7:0] PRESCALE_DEF = 8'd24;

    typedef enum logic [2:0] {
        REG_CNT_LO   = 3'd0,
        REG_CNT_HI   = 3'd1,
        REG_RLD_LO   = 3'd2,
        REG_RLD_HI   = 3'd3,
        REG_CTRL     = 3'd4,
        REG_STATUS   = 3'd5,
        REG_PRESCALE = 3'd6
    } reg_t;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int STAT_EXP     = 0;
    localparam int STAT_RUN     = 1;

    typedef struct packed {
        logic oneshot;
        logic ie;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: counts 0..divisor while enabled and pulses tick on wrap; divisor is latched per period
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] divisor,
    output logic       tick
);

    logic [7:0] cnt;
    logic [7:0] limit;

    assign tick = enable && !clear && (cnt == limit);

    // restart the period on reset, clear or wrap, picking up the current divisor only then
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt   <= 8'd0;
            limit <= divisor;
        end else if (enable) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/timer_irq.sv
// timer_irq: 16-bit reloading down-counter with prescaler and interrupt; define TIMER_SNAPSHOT_EN for atomic CNT_LO/CNT_HI reads
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [7:0] PRESCALE_RST = PRESCALE_DEF
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       rd,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq_n
);

    reg_t        sel;
    ctrl_t       ctrl;
    logic [15:0] count;
    logic [15:0] reload;
    logic [7:0]  prescale;
    logic        exp;
    logic        tick;
    logic        wr_ctrl;
    logic        en_rise;
    logic        expire;
    logic        w1c;
    logic [7:0]  cnt_hi;
    logic        unused;

    assign sel     = reg_t'(addr[2:0]);
    assign wr_ctrl = we && (sel == REG_CTRL);
    assign en_rise = wr_ctrl && data_in[CTRL_EN] && !ctrl.en;
    assign expire  = tick && (count == 16'd0);
    assign w1c     = we && (sel == REG_STATUS) && data_in[STAT_EXP];

    timer_prescaler u_prescaler (
        .clk     (clk_25mhz),
        .rst     (rst),
        .enable  (ctrl.en),
        .clear   (en_rise),
        .divisor (prescale),
        .tick    (tick)
    );

    // register writes, counter update, expiry flag and registered interrupt
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            count    <= 16'd0;
            reload   <= 16'd0;
            ctrl     <= '0;
            exp      <= 1'b0;
            prescale <= PRESCALE_RST;
            irq_n    <= 1'b1;
        end else begin
            if (we && sel == REG_RLD_LO) reload[7:0] <= data_in;
            if (we && sel == REG_RLD_HI) reload[15:8] <= data_in;
            if (we && sel == REG_PRESCALE) prescale <= data_in;
            if (wr_ctrl) ctrl <= ctrl_t'(data_in[2:0]);
            if (en_rise) count <= reload;
            else if (tick) count <= (count != 16'd0) ? count - 16'd1 : (ctrl.oneshot ? 16'd0 : reload);
            if (expire && ctrl.oneshot) ctrl.en <= 1'b0;
            exp   <= expire || (exp && !w1c);
            irq_n <= !(exp && ctrl.ie);
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [7:0] snap;

    // latch the high byte when the low byte is read so a LO-then-HI pair is coherent
    always_ff @(posedge clk_25mhz) begin
        if (rst) snap <= 8'h00;
        else if (rd && sel == REG_CNT_LO) snap <= count[15:8];
    end

    assign cnt_hi = snap;
    assign unused = ^{cs, addr[7:3]};
`else
    assign cnt_hi = count[15:8];
    assign unused = ^{cs, rd, addr[7:3]};
`endif

    // read mux, combinational from the low address bits
    always_comb begin
        case (sel)
            REG_CNT_LO:   data_out = count[7:0];
            REG_CNT_HI:   data_out = cnt_hi;
            REG_RLD_LO:   data_out = reload[7:0];
            REG_RLD_HI:   data_out = reload[15:8];
            REG_CTRL:     data_out = {5'd0, ctrl};
            REG_STATUS:   data_out = {6'd0, ctrl.en, exp};
            REG_PRESCALE: data_out = prescale;
            default:      data_out = 8'h00;
        endcase
    end

endmodule
